// File: rtl/integrator_pkg.sv
// Shared types and helpers for the windowed integrator (states, mode encodings, width helper).
package integrator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACCUM,
    HOLD
  } state_t;

  localparam logic MODE_BLOCK = 1'b0;
  localparam logic MODE_SLIDE = 1'b1;

  function automatic int out_width(input int word_size, input int samples);
    return word_size + $clog2(samples);
  endfunction

endpackage

// File: rtl/integrator_window_ctrl.sv
// Window controller: FSM, sample counter, buffer pointer, restart/mode-change detect and valid.
module integrator_window_ctrl
  import integrator_pkg::*;
#(
  parameter int SAMPLES = 4,
  parameter int CNT_W   = $clog2(SAMPLES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  output logic             load,
  output logic             acc_en,
  output logic             sub_en,
  output logic             valid_next,
  output logic [CNT_W-1:0] wr_ptr,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             valid_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLES - 1);

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ptr_q, ptr_d;
  logic             valid_q;
  logic             mode_chg;

  assign mode_chg = (mode != mode_q);

  // A consumed sample is either a restart (load) or a continuation (acc_en); cnt saturating
  // at LAST doubles as the "window filled" flag for both valid and the sliding subtraction.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    valid_next = 1'b0;
    load       = 1'b0;
    acc_en     = 1'b0;
    sub_en     = 1'b0;
    if (enable) begin
      mode_d = mode;
      unique case (state_q)
        IDLE, LOAD: load = 1'b1;
        ACCUM:      load = mode_chg;
        HOLD:       load = mode_chg || (mode == MODE_BLOCK);
      endcase
      if (load) begin
        cnt_d   = '0;
        ptr_d   = CNT_W'(1);
        state_d = ACCUM;
      end else begin
        acc_en  = 1'b1;
        sub_en  = (cnt_q == LAST);
        cnt_d   = (cnt_q == LAST) ? LAST : cnt_q + CNT_W'(1);
        ptr_d   = (ptr_q == LAST) ? '0 : ptr_q + CNT_W'(1);
        state_d = ((mode == MODE_BLOCK) && (cnt_d == LAST)) ? LOAD : ACCUM;
      end
      valid_next = (cnt_d == LAST);
    end else if (state_q == ACCUM) begin
      state_d = HOLD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_BLOCK;
      cnt_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_next;
    end
  end

  assign wr_ptr     = ptr_q;
  assign sample_cnt = cnt_q;
  assign valid_out  = valid_q;

endmodule

// File: rtl/integrator_window_dpc.sv
// Block / sliding-window integrator datapath (accumulator + sample ring buffer).
// Optional INTEGRATOR_AVG_EN adds a registered window average output data_avg.
module integrator_window_dpc
  import integrator_pkg::*;
#(
  parameter int WORD_SIZE = 3,
  parameter int SAMPLES   = 4,
  parameter int CNT_W     = $clog2(SAMPLES),
  parameter int OUT_W     = out_width(WORD_SIZE, SAMPLES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [OUT_W-1:0]     data_out,
`ifdef INTEGRATOR_AVG_EN
  output logic [WORD_SIZE-1:0] data_avg,
`endif
  output logic                 valid_out,
  output logic [CNT_W-1:0]     sample_cnt
);

  if (SAMPLES < 2 || SAMPLES > 64) begin : g_bad_samples
    $error("SAMPLES must be in 2..64");
  end

  logic                 load, acc_en, sub_en, valid_next;
  logic [CNT_W-1:0]     wr_ptr, widx;
  logic [OUT_W-1:0]     acc_q, acc_d;
  logic [WORD_SIZE-1:0] buf_q [SAMPLES];
  logic [WORD_SIZE-1:0] buf_d [SAMPLES];

  integrator_window_ctrl #(
    .SAMPLES(SAMPLES),
    .CNT_W  (CNT_W)
  ) u_ctrl (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .load      (load),
    .acc_en    (acc_en),
    .sub_en    (sub_en),
    .valid_next(valid_next),
    .wr_ptr    (wr_ptr),
    .sample_cnt(sample_cnt),
    .valid_out (valid_out)
  );

  assign widx = load ? '0 : wr_ptr;

  always_comb begin
    acc_d = acc_q;
    buf_d = buf_q;
    if (load) begin
      acc_d = OUT_W'(data_in);
    end else if (acc_en) begin
      acc_d = acc_q + OUT_W'(data_in) - (sub_en ? OUT_W'(buf_q[wr_ptr]) : '0);
    end
    if (load || acc_en) begin
      buf_d[widx] = data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      for (int unsigned i = 0; i < SAMPLES; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      buf_q <= buf_d;
    end
  end

  assign data_out = acc_q;

`ifdef INTEGRATOR_AVG_EN
  if ((1 << $clog2(SAMPLES)) != SAMPLES) begin : g_bad_avg
    $error("INTEGRATOR_AVG_EN requires SAMPLES to be a power of two");
  end

  logic [WORD_SIZE-1:0] data_avg_q, data_avg_d;

  assign data_avg_d = valid_next ? acc_d[OUT_W-1:CNT_W] : data_avg_q;

  always_ff @(posedge clock) begin
    if (reset) data_avg_q <= '0;
    else       data_avg_q <= data_avg_d;
  end

  assign data_avg = data_avg_q;
`endif

endmodule

// File: tb/tb_integrator_window_dpc.sv
// Self-checking bench for integrator_window_dpc (WORD_SIZE=3, SAMPLES=4); queue-based window model.
module tb_integrator_window_dpc;

  localparam int W = 3;
  localparam int N = 4;
  localparam int OW = W + $clog2(N);
  localparam int CW = $clog2(N);

  logic          clock = 1'b0;
  logic          reset, enable, mode;
  logic [W-1:0]  data_in;
  logic [OW-1:0] data_out;
  logic          valid_out;
  logic [CW-1:0] sample_cnt;
`ifdef INTEGRATOR_AVG_EN
  logic [W-1:0]  data_avg;
`endif

  integrator_window_dpc #(
    .WORD_SIZE(W),
    .SAMPLES  (N)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .data_in   (data_in),
    .data_out  (data_out),
`ifdef INTEGRATOR_AVG_EN
    .data_avg  (data_avg),
`endif
    .valid_out (valid_out),
    .sample_cnt(sample_cnt)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: the samples of the current window since the last restart.
  int win[$];
  bit pend = 1'b1, held = 1'b0, last_mode = 1'b0;
  int e_out = 0, e_cnt = 0, e_avg = 0;
  bit e_val = 1'b0;

  task automatic model_step(input bit r, input bit e, input bit m, input int d);
    bit restart;
    int s;
    if (r) begin
      win.delete();
      pend = 1'b1; held = 1'b0; last_mode = 1'b0;
      e_out = 0; e_cnt = 0; e_val = 1'b0; e_avg = 0;
    end else if (e) begin
      restart = pend || (m != last_mode) || (held && m == 1'b0);
      if (restart) win.delete();
      win.push_back(d);
      if (win.size() > N) void'(win.pop_front());
      s = 0;
      foreach (win[i]) s += win[i];
      e_out = s;
      e_cnt = win.size() - 1;
      e_val = (win.size() == N);
      if (e_val) e_avg = s / N;
      pend = (m == 1'b0) && e_val;
      held = 1'b0;
      last_mode = m;
    end else begin
      e_val = 1'b0;
      held = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("model data_out", int'(data_out), e_out);
      chk("model valid_out", int'(valid_out), int'(e_val));
      chk("model sample_cnt", int'(sample_cnt), e_cnt);
`ifdef INTEGRATOR_AVG_EN
      chk("model data_avg", int'(data_avg), e_avg);
`endif
    end
  end

  task automatic cyc(input bit r, input bit e, input bit m, input int d);
    reset = r; enable = e; mode = m; data_in = W'(d);
    @(posedge clock);
    model_step(r, e, m, d);
    @(negedge clock);
  endtask

  task automatic lit(input string nm, input int o, input int v, input int c);
    chk({nm, " out"}, int'(data_out), o);
    chk({nm, " valid"}, int'(valid_out), v);
    chk({nm, " cnt"}, int'(sample_cnt), c);
  endtask

  int bin[5]  = '{1, 2, 3, 4, 7};
  int bo[5]   = '{1, 3, 6, 10, 7};
  int bv[5]   = '{0, 0, 0, 1, 0};
  int bc[5]   = '{0, 1, 2, 3, 0};
  int sin_[6] = '{7, 7, 7, 7, 1, 0};
  int so[6]   = '{7, 14, 21, 28, 22, 15};
  int sv[6]   = '{0, 0, 0, 1, 1, 1};

  initial begin
    reset = 1'b1; enable = 1'b1; mode = 1'b0; data_in = '0;
    // reset wins over enable
    cyc(1, 1, 0, 5);
    chk_en = 1'b1;
    cyc(1, 1, 0, 5);
    lit("reset", 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, bin[i]);
      lit("block", bo[i], bv[i], bc[i]);
    end

    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 6);
      lit("block hold", 3, 0, 1);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 5);
      lit("block resume", 5 * (i + 1), (i == 3) ? 1 : 0, i);
    end

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 1, sin_[i]);
      lit("slide", so[i], sv[i], (i < 3) ? i : 3);
    end
    cyc(0, 0, 1, 3);
    cyc(0, 0, 1, 3);
    lit("slide hold", 15, 0, 3);
    cyc(0, 1, 1, 0);
    lit("slide resume", 8, 1, 3);

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 7);
    lit("block max", 28, 1, 3);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 2);
    lit("after max", 3, 0, 1);
    cyc(1, 1, 0, 4);
    lit("mid reset", 0, 0, 0);
    cyc(0, 1, 0, 3);
    lit("post reset load", 3, 0, 0);

    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 2);
    cyc(0, 1, 1, 4);
    lit("mode switch", 4, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 4);
      lit("post switch", 8 + 4 * i, (i == 2) ? 1 : 0, i + 1);
    end

    // mode change while held restarts at resume
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 6);
    lit("hold mode switch", 6, 0, 0);

    for (int i = 0; i < 120; i++) begin
      cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
          (i / 30) % 2 == 1 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0),
          $urandom_range(0, 7));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
